// File: rtl/pwm_channel_sequencer.sv
// pwm_channel_sequencer
// Up to four PWM outputs share one free-running period counter. Each channel
// holds a target duty written over a valid/ready config port and an active
// duty that drives the pin. Active only changes at the last count of a period,
// either jumping to the target or fading one LSB every RAMP_DIV periods.
//
// Config handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high. cfg_ready is low in the update cycle, where
// counter == COUNTER_LIMIT, and while rst_n is low. It does not depend on
// cfg_valid, so a master may hold cfg_valid high and simply wait.
`timescale 1ns/1ps
module pwm_channel_sequencer #(
  parameter int         CHANNELS      = 3,
  parameter logic [7:0] COUNTER_LIMIT = 8'd255,
  parameter int         RAMP_DIV      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_chan,
  input  logic [7:0]          cfg_duty,
  input  logic                cfg_ramp,
  output logic [CHANNELS-1:0] opin,
  output logic                period_start,
  output logic [CHANNELS-1:0] busy
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ch_state_t;

  logic [7:0]    counter;
  logic [RW-1:0] ramp_cnt;
  logic          period_start_q;
  logic          update_cycle;
  logic          ramp_tick;
  logic          cfg_fire;

  assign update_cycle = (counter == COUNTER_LIMIT);
  assign ramp_tick    = update_cycle && (ramp_cnt == RW'(RAMP_DIV - 1));
  assign cfg_ready    = rst_n && !update_cycle;
  assign cfg_fire     = cfg_valid && cfg_ready;
  assign period_start = period_start_q;

  // Shared period counter, fade prescaler and the registered period marker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter        <= 8'd0;
      ramp_cnt       <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= (counter == 8'd0);
      if (update_cycle) begin
        counter <= 8'd0;
        if (ramp_cnt == RW'(RAMP_DIV - 1)) begin
          ramp_cnt <= '0;
        end else begin
          ramp_cnt <= ramp_cnt + RW'(1);
        end
      end else begin
        counter <= counter + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [7:0] target;
    logic [7:0] active;
    logic       mode;
    ch_state_t  state;
    logic       opin_q;
    logic [7:0] step_active;

    // Candidate active duty after this period's fade step; the step is a
    // single LSB toward target, so it can never overshoot or wrap.
    always_comb begin
      step_active = active;
      if (mode && ramp_tick) begin
        if (active < target) begin
          step_active = active + 8'd1;
        end else if (active > target) begin
          step_active = active - 8'd1;
        end
      end
    end

    // Channel sequencer: config capture, period-boundary apply, pin output.
    // Channel indices >= CHANNELS never match here, so such writes are dropped.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        target <= 8'd0;
        active <= 8'd0;
        mode   <= 1'b0;
        state  <= IDLE;
        opin_q <= 1'b0;
      end else begin
        opin_q <= (counter < active);
        if (update_cycle) begin
          if (!mode) begin
            active <= target;
            state  <= IDLE;
          end else begin
            active <= step_active;
            if (step_active == target) begin
              state <= IDLE;
            end else if (step_active < target) begin
              state <= RAMP_UP;
            end else begin
              state <= RAMP_DOWN;
            end
          end
        end
        if (cfg_fire && (cfg_chan == 2'(i))) begin
          target <= cfg_duty;
          mode   <= cfg_ramp;
        end
      end
    end

    assign opin[i] = opin_q;
    assign busy[i] = (state != IDLE) || (target != active);
  end

endmodule

// File: doc/pwm_channel_sequencer.md
# pwm_channel_sequencer

Three-channel PWM controller that time-shares one free-running 8-bit period counter among all output channels and sequences each channel's duty cycle. Duty updates arrive over a valid/ready configuration port. They are applied only at period boundaries, either immediately or as a linear fade (one LSB step per RAMP_DIV periods). The block sits between the register/config master and the PWM output pins, replacing per-channel fixed-duty generators.

## Interface

Parameters:
- CHANNELS, 3: number of PWM outputs (1–4).
- COUNTER_LIMIT, 8'd255: terminal count; period = COUNTER_LIMIT+1 cycles.
- RAMP_DIV, 4: periods per fade step (≥1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept; transfer when cfg_valid && cfg_ready.
- cfg_chan  input  2  target channel index.
- cfg_duty  input  8  target duty (high count per period).
- cfg_ramp  input  1  1 = fade to target, 0 = jump to target.
- opin  output  CHANNELS  PWM outputs, registered.
- period_start  output  1  one-cycle pulse, counter == 0.
- busy  output  CHANNELS  channel i not yet at target.

## Operation

- Counter: increments each cycle; at COUNTER_LIMIT wraps to 0 on the next edge. The cycle where counter == COUNTER_LIMIT is the *update cycle*.
- Per channel: `target[i]`, `active[i]`, `mode[i]`, and state ∈ {IDLE, RAMP_UP, RAMP_DOWN}.
- Config accept:
  - Writes `target[cfg_chan]` and `mode[cfg_chan]`.
  - cfg_chan ≥ CHANNELS: accepted, no effect.
  - Multiple writes to one channel before an update cycle: last write wins.
- cfg_ready: 1 in every cycle except the update cycle and while rst_n = 0.
- Ramp tick: a period counter 0..RAMP_DIV-1 advances at each update cycle. `ramp_tick` is true in the update cycle where it equals RAMP_DIV-1.
- Update cycle, per channel:
  - mode = jump: `active <= target`, state → IDLE.
  - mode = ramp, active < target: state RAMP_UP; on `ramp_tick`, active += 1.
  - mode = ramp, active > target: state RAMP_DOWN; on `ramp_tick`, active −= 1.
  - active == target (after the step): state → IDLE.
- Retarget mid-ramp: the fade continues from the current `active` toward the new target, with direction recomputed. A jump write mid-ramp aborts the fade at the next update cycle.
- busy[i] = (state ≠ IDLE) or (target[i] ≠ active[i]).
- Output: opin[i] <= (counter < active[i]), registered.
  - Duty 0: constantly low.
  - Duty ≥ COUNTER_LIMIT+1: constantly high.
  - Duty 255 with limit 255: high 255 of 256 cycles.
- Arithmetic: all compares are unsigned 8-bit. Ramp steps never overshoot and never wrap past 0 or 255.

## Timing

- Reset values, set on the first clk edge with rst_n = 0:
  - counter = 0, active = 0, target = 0, mode = jump, ramp counter = 0, states IDLE.
  - opin = 0, busy = 0, period_start = 0, cfg_ready = 0.
- After reset: cfg_ready = 1 in the first cycle with rst_n = 1. counter = 0 in that cycle, and period_start asserts one cycle later (registered).
- opin latency: opin reflects the counter value of the previous cycle. period_start is likewise registered, aligned with opin bit for count 0.
- Config write to first effect on opin:
  - Write accepted in cycle t; the next update cycle u ≥ t+1 latches `active`.
  - New duty is visible on opin from cycle u+2, i.e. the first full period.
  - A write cannot land in the update cycle because cfg_ready = 0 there.
- Fade duration: |target − active| × RAMP_DIV periods, ±1 RAMP_DIV window for phase.
- Reset mid-operation: all state returns to reset values on the next edge. opin drops to 0 one edge after rst_n samples 0.

## Test plan

- Reset, then jump write ch0 duty 128 → ch0 high exactly 128 cycles of every 256. period_start pulses every 256 cycles. busy[0] = 0 after apply.
- Jump write ch1 = 0 and ch2 = 255 → ch1 never high; ch2 low exactly 1 cycle per period.
- Ramp write ch0 0→4 with RAMP_DIV = 4 → high-count per period steps 0,1,2,3,4, one step every 4 periods. busy[0] falls in the update cycle reaching 4.
- Ramp ch1 to 10, then retarget to 2 while active = 6 → sequence descends 6,5,4,3,2 with no overshoot and no wrap.
- Hold cfg_valid continuously → cfg_ready = 0 only in cycles with counter = 255. Writes to cfg_chan = 3 are accepted and leave all outputs unchanged.
- Assert rst_n = 0 mid-fade for 1 cycle → opin, busy, active, target all 0. Counter restarts at 0 and cfg_ready = 0 during reset.
